id_ex_reg: RTL and testbench

ID/EX pipeline register of the five-stage RISC-V core, sitting directly downstream of the decode-stage controller. It captures the controller's control bundle plus decoded operands every cycle and presents them to EX. It detects load-use hazards, and on a hazard inserts a bubble while stalling PC and IF/ID. On a taken branch or jump from EX it flushes the decode-stage instruction.

---
 rtl/pipe_pkg.sv | 34 +++
 rtl/hazard_detect.sv | 22 ++
 rtl/id_ex_reg.sv | 162 ++++++++++++++++
 tb/tb_id_ex_reg.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// pipe_pkg: shared control bundle, NOP constant and opcodes for the 5-stage core.
// Revision: 1.0
package pipe_pkg;

  typedef struct packed {
    logic       ALUSrc;
    logic       MemtoReg;
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic [1:0] ALUOp;
    logic       Branch;
    logic [1:0] MUX_final;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// hazard_detect: combinational load-use hazard and stall generation for ID/EX.
// Revision: 1.0
module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       flush,
  output logic       hz,
  output logic       stall
);

  // Both source fields compared regardless of format; I-type false stalls are tolerated.
  assign hz    = ex_valid & ex_memread & id_valid & (ex_rd != 5'd0) &
                 ((ex_rd == id_rs1) | (ex_rd == id_rs2));
  assign stall = hz & ~flush;

endmodule
`default_nettype wire

// File: rtl/id_ex_reg.sv
`default_nettype none
// id_ex_reg: ID/EX pipeline register with load-use bubble insertion and flush.
// HAZARD_STATS_EN adds saturating bubble_cnt/flush_cnt outputs. Revision: 1.0
module id_ex_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  ctrl_t             id_ctrl,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic              flush,
  output logic              ex_valid,
  output ctrl_t             ex_ctrl,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [PC_W-1:0]   ex_pc,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic              stall
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0]       bubble_cnt,
  output logic [15:0]       flush_cnt
`endif
);

  logic              valid_q, valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [2:0]        f3_q, f3_d;
  logic [6:0]        f7_q, f7_d;
  logic              w_hz;

  hazard_detect u_hazard_detect (
    .ex_valid   (valid_q),
    .ex_memread (ctrl_q.MemRead),
    .ex_rd      (rd_q),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .flush      (flush),
    .hz         (w_hz),
    .stall      (stall)
  );

  // A bubble only kills valid/ctrl; operand fields keep their last values.
  always_comb begin
    valid_d = 1'b0;
    ctrl_d  = CTRL_NOP;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    rd1_d   = rd1_q;
    rd2_d   = rd2_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    f3_d    = f3_q;
    f7_d    = f7_q;
    if (!(flush || w_hz)) begin
      valid_d = id_valid;
      ctrl_d  = id_valid ? id_ctrl : CTRL_NOP;
      rs1_d   = id_rs1;
      rs2_d   = id_rs2;
      rd_d    = id_rd;
      rd1_d   = id_rd1;
      rd2_d   = id_rd2;
      imm_d   = id_imm;
      pc_d    = id_pc;
      f3_d    = id_funct3;
      f7_d    = id_funct7;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= CTRL_NOP;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      rd1_q   <= '0;
      rd2_q   <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      f3_q    <= '0;
      f7_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      f3_q    <= f3_d;
      f7_q    <= f7_d;
    end
  end

  assign ex_valid  = valid_q;
  assign ex_ctrl   = ctrl_q;
  assign ex_rs1    = rs1_q;
  assign ex_rs2    = rs2_q;
  assign ex_rd     = rd_q;
  assign ex_rd1    = rd1_q;
  assign ex_rd2    = rd2_q;
  assign ex_imm    = imm_q;
  assign ex_pc     = pc_q;
  assign ex_funct3 = f3_q;
  assign ex_funct7 = f7_q;

`ifdef HAZARD_STATS_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Flush outranks the hazard, so a flushed hazard is counted only as a flush.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (flush) begin
      if (id_valid) flush_cnt_d = sat_inc16(flush_cnt_q);
    end else if (w_hz) begin
      bubble_cnt_d = sat_inc16(bubble_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign flush_cnt  = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_id_ex_reg.sv
`default_nettype none
// tb_id_ex_reg: scoreboard bench for id_ex_reg; counter checks under HAZARD_STATS_EN.
// Revision: 1.0
module tb_id_ex_reg;
  import pipe_pkg::*;

  localparam int DW = 32;
  localparam int PW = 9;

  typedef struct packed {
    logic          v;
    ctrl_t         c;
    logic [4:0]    rs1, rs2, rd;
    logic [DW-1:0] rd1, rd2, imm;
    logic [PW-1:0] pc;
    logic [2:0]    f3;
    logic [6:0]    f7;
  } slot_t;

  localparam ctrl_t C_ADDI = '{ALUSrc:1'b1, MemtoReg:1'b0, RegWrite:1'b1, MemRead:1'b0,
                               MemWrite:1'b0, ALUOp:2'b10, Branch:1'b0, MUX_final:2'b00};
  localparam ctrl_t C_ADD  = '{ALUSrc:1'b0, MemtoReg:1'b0, RegWrite:1'b1, MemRead:1'b0,
                               MemWrite:1'b0, ALUOp:2'b10, Branch:1'b0, MUX_final:2'b00};
  localparam ctrl_t C_LW   = '{ALUSrc:1'b1, MemtoReg:1'b1, RegWrite:1'b1, MemRead:1'b1,
                               MemWrite:1'b0, ALUOp:2'b00, Branch:1'b0, MUX_final:2'b01};
  localparam ctrl_t C_SW   = '{ALUSrc:1'b1, MemtoReg:1'b0, RegWrite:1'b0, MemRead:1'b0,
                               MemWrite:1'b1, ALUOp:2'b00, Branch:1'b0, MUX_final:2'b00};

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          flush = 1'b0;
  slot_t         id_s = '0;
  logic          ex_valid, stall;
  ctrl_t         ex_ctrl;
  logic [4:0]    ex_rs1, ex_rs2, ex_rd;
  logic [DW-1:0] ex_rd1, ex_rd2, ex_imm;
  logic [PW-1:0] ex_pc;
  logic [2:0]    ex_funct3;
  logic [6:0]    ex_funct7;
`ifdef HAZARD_STATS_EN
  logic [15:0]   bubble_cnt, flush_cnt;
`endif

  always #5 clk = ~clk;

  id_ex_reg #(.DATA_W(DW), .PC_W(PW)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_s.v), .id_ctrl(id_s.c),
    .id_rs1(id_s.rs1), .id_rs2(id_s.rs2), .id_rd(id_s.rd),
    .id_rd1(id_s.rd1), .id_rd2(id_s.rd2), .id_imm(id_s.imm),
    .id_pc(id_s.pc), .id_funct3(id_s.f3), .id_funct7(id_s.f7),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_pc(ex_pc), .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .stall(stall)
`ifdef HAZARD_STATS_EN
    , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
  );

  int          chk_cnt = 0;
  int          pass_cnt = 0;
  slot_t       exp_q[$];
  slot_t       m_ex = '0;
  logic [15:0] m_bub = '0;
  logic [15:0] m_fl = '0;
  logic [PW-1:0] pc_ctr = '0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] expv);
    chk_cnt++;
    if (obs === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
  endtask

  function automatic slot_t mk(input ctrl_t c, input logic [4:0] rd,
                               input logic [4:0] rs1, input logic [4:0] rs2);
    slot_t s;
    s.v   = 1'b1;
    s.c   = c;
    s.rd  = rd;
    s.rs1 = rs1;
    s.rs2 = rs2;
    s.rd1 = $urandom;
    s.rd2 = $urandom;
    s.imm = $urandom;
    s.pc  = pc_ctr;
    s.f3  = 3'($urandom);
    s.f7  = 7'($urandom);
    pc_ctr = pc_ctr + 9'd4;
    return s;
  endfunction

  function automatic logic [129:0] fields(input slot_t s);
    return {s.rs1, s.rs2, s.rd, s.rd1, s.rd2, s.imm, s.pc, s.f3, s.f7};
  endfunction

  // One cycle: drive, check combinational stall, push expected EX state, compare after edge.
  task automatic step(input slot_t s, input logic fl, input logic rst_n, output logic st);
    logic  hz;
    slot_t n, e;
    @(negedge clk);
    id_s  = s;
    flush = fl;
    reset = rst_n;
    #1;
    hz = m_ex.v & m_ex.c.MemRead & s.v & (m_ex.rd != 5'd0) &
         ((m_ex.rd == s.rs1) | (m_ex.rd == s.rs2));
    st = hz & ~fl;
    check("stall", stall, st);
    n = m_ex;
    if (!rst_n) begin
      n = '0; m_bub = '0; m_fl = '0;
    end else if (fl) begin
      n.v = 1'b0; n.c = CTRL_NOP;
      if (s.v && m_fl != 16'hFFFF) m_fl = m_fl + 16'd1;
    end else if (hz) begin
      n.v = 1'b0; n.c = CTRL_NOP;
      if (m_bub != 16'hFFFF) m_bub = m_bub + 16'd1;
    end else begin
      n = s;
      if (!s.v) n.c = CTRL_NOP;
    end
    m_ex = n;
    exp_q.push_back(n);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("ex_valid", ex_valid, e.v);
    check("ex_ctrl", ex_ctrl, e.c);
    check("ex_fields", {ex_rs1, ex_rs2, ex_rd, ex_rd1, ex_rd2, ex_imm, ex_pc, ex_funct3, ex_funct7},
          fields(e));
`ifdef HAZARD_STATS_EN
    check("bubble_cnt", bubble_cnt, m_bub);
    check("flush_cnt", flush_cnt, m_fl);
`endif
  endtask

  // Holds the instruction in ID while stalled, as IF/ID would.
  task automatic issue(input slot_t s, output int stalls);
    logic st;
    bit   done = 1'b0;
    stalls = 0;
    for (int k = 0; k < 4 && !done; k++) begin
      step(s, 1'b0, 1'b1, st);
      if (st) stalls++;
      else done = 1'b1;
    end
    if (!done) check("issue_timeout", 1, 0);
  endtask

  task automatic do_reset();
    logic st;
    step('0, 1'b0, 1'b0, st);
  endtask

  initial begin
    int    ns;
    logic  st;
    slot_t r;

    do_reset();
    do_reset();

    issue(mk(C_ADDI, 5'd1, 5'd0, 5'd0), ns);
    check("b2b_stall1", ns, 0);
    issue(mk(C_ADDI, 5'd2, 5'd0, 5'd0), ns);
    check("b2b_stall2", ns, 0);

    do_reset();
    issue(mk(C_LW, 5'd5, 5'd1, 5'd0), ns);
    issue(mk(C_ADD, 5'd6, 5'd5, 5'd7), ns);
    check("lu_stalls", ns, 1);
    check("lu_add_valid", ex_valid, 1);
    check("lu_add_rd", ex_rd, 5'd6);

    issue(mk(C_LW, 5'd0, 5'd1, 5'd0), ns);
    issue(mk(C_ADD, 5'd6, 5'd0, 5'd1), ns);
    check("x0_stalls", ns, 0);

    do_reset();
    issue(mk(C_LW, 5'd5, 5'd1, 5'd0), ns);
    step(mk(C_ADD, 5'd6, 5'd5, 5'd7), 1'b1, 1'b1, st);
    check("fl_stall", st, 0);
    check("fl_ex_valid", ex_valid, 0);
`ifdef HAZARD_STATS_EN
    check("fl_flush_cnt", flush_cnt, 16'd1);
    check("fl_bubble_cnt", bubble_cnt, 16'd0);
`endif

    issue(mk(C_SW, 5'd0, 5'd2, 5'd3), ns);
    check("rst_pre_memwrite", ex_ctrl.MemWrite, 1);
    step(mk(C_ADD, 5'd4, 5'd1, 5'd2), 1'b0, 1'b0, st);
    check("rst_ex_valid", ex_valid, 0);
    check("rst_ex_ctrl", ex_ctrl, 10'd0);

    for (int i = 0; i < 400; i++) begin
      r = mk(ctrl_t'(10'($urandom)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      r.v = ($urandom_range(0, 9) != 0);
      step(r, ($urandom_range(0, 9) == 0), ($urandom_range(0, 49) != 0), st);
    end

`ifdef HAZARD_STATS_EN
    do_reset();
    issue(mk(C_LW, 5'd5, 5'd5, 5'd0), ns);
    force dut.bubble_cnt_q = 16'hFFFC;
    #1;
    release dut.bubble_cnt_q;
    m_bub = 16'hFFFC;
    for (int i = 0; i < 8; i++) issue(mk(C_LW, 5'd5, 5'd5, 5'd0), ns);
    check("sat_bubble_cnt", bubble_cnt, 16'hFFFF);
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
